// File: rtl/if_id_queue.sv
// ---------------------------------------------------------------------------
// if_id_queue
//
// Decoupling queue between instruction fetch and decode. It holds up to
// DEPTH {pc, instr} pairs so that decode back-pressure never stalls the PC
// register in the middle of a fetch. A single-cycle flush empties the queue
// on a control-flow redirect.
//
// For the head entry, decode also receives:
//   - the static next PC (pc + 4, wrapping), and
//   - a misalignment flag, which is computed when the entry is pushed.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active-low
//   in_valid     fetch presents {in_pc, in_instr}
//   in_ready     queue accepts the entry this cycle
//   in_pc        PC of the fetched instruction
//   in_instr     fetched instruction word
//   out_valid    head entry valid toward decode
//   out_ready    decode consumes the head entry this cycle
//   out_pc       PC of the head entry (0 when empty)
//   out_instr    instruction of the head entry (0 when empty)
//   out_snpc     out_pc + 4, modulo 2^PC_W
//   out_misalign out_pc[1:0] != 0 for the head entry (0 when empty)
//   flush        redirect: discards every entry on the next edge
//   count        number of stored entries
// ---------------------------------------------------------------------------
module if_id_queue #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 64,
  parameter int INST_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [INST_W-1:0]        in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [INST_W-1:0]        out_instr,
  output logic [PC_W-1:0]          out_snpc,
  output logic                     out_misalign,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [AW-1:0]   PTR_ONE   = AW'(1'b1);
  localparam logic [AW-1:0]   PTR_ZERO  = AW'(1'b0);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1'b1);
  localparam logic [CW-1:0]   CNT_ZERO  = CW'(1'b0);
  localparam logic [CW-1:0]   CNT_FULL  = CW'(DEPTH);
  localparam logic [PC_W-1:0] PC_FOUR   = PC_W'(3'd4);

  // Low two PC bits nonzero means the instruction is not word-aligned.
  function automatic logic is_misaligned(input logic [PC_W-1:0] pc);
    return (pc[1:0] != 2'b00);
  endfunction

  logic [PC_W-1:0]   pc_mem_r    [DEPTH];
  logic [INST_W-1:0] instr_mem_r [DEPTH];
  logic              mis_mem_r   [DEPTH];

  logic [AW-1:0] head_r;
  logic [AW-1:0] tail_r;
  logic [CW-1:0] count_r;

  logic          not_empty_s;
  logic          not_full_s;
  logic          push_s;
  logic          pop_s;

  // Handshake qualification; flush suppresses both sides for this cycle.
  always_comb begin
    not_empty_s = (count_r != CNT_ZERO);
    not_full_s  = (count_r != CNT_FULL);
    in_ready    = not_full_s & ~flush;
    out_valid   = not_empty_s;
    // in_ready already contains ~flush; pop must mask it explicitly.
    push_s      = in_valid & in_ready;
    pop_s       = not_empty_s & out_ready & ~flush;
  end

  // Pointer and occupancy state. Reset dominates flush, and flush dominates traffic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_r  <= PTR_ZERO;
      tail_r  <= PTR_ZERO;
      count_r <= CNT_ZERO;
    end else if (flush) begin
      head_r  <= PTR_ZERO;
      tail_r  <= PTR_ZERO;
      count_r <= CNT_ZERO;
    end else begin
      if (push_s) begin
        tail_r <= tail_r + PTR_ONE;
      end
      if (pop_s) begin
        head_r <= head_r + PTR_ONE;
      end
      if (push_s && !pop_s) begin
        count_r <= count_r + CNT_ONE;
      end else if (pop_s && !push_s) begin
        count_r <= count_r - CNT_ONE;
      end else begin
        count_r <= count_r;
      end
    end
  end

  // Payload storage; its contents are irrelevant until written, so it is not reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      pc_mem_r[tail_r]    <= in_pc;
      instr_mem_r[tail_r] <= in_instr;
      mis_mem_r[tail_r]   <= is_misaligned(in_pc);
    end
  end

  // Head read-out. The payload is forced to zero when empty, so out_snpc is 4.
  always_comb begin
    out_pc       = {PC_W{1'b0}};
    out_instr    = {INST_W{1'b0}};
    out_misalign = 1'b0;
    if (not_empty_s) begin
      out_pc       = pc_mem_r[head_r];
      out_instr    = instr_mem_r[head_r];
      out_misalign = mis_mem_r[head_r];
    end else begin
      out_pc       = {PC_W{1'b0}};
      out_instr    = {INST_W{1'b0}};
      out_misalign = 1'b0;
    end
    out_snpc = out_pc + PC_FOUR;
  end

  assign count = count_r;

endmodule

// File: tb/tb_if_id_queue.sv
// ---------------------------------------------------------------------------
// tb_if_id_queue
//
// Directed bench for if_id_queue. A table of vectors is applied one cycle
// per entry. Each vector gives:
//   - the inputs for that cycle,
//   - the in_ready expected before the edge, and
//   - the head/count state expected after the edge.
// Hand-written sequences cover asynchronous reset and the wrap-around edge values.
// ---------------------------------------------------------------------------
module tb_if_id_queue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic [63:0] out_snpc;
  logic        out_misalign;
  logic        flush;
  logic [2:0]  count;

  int total;
  int bad;
  int cur;

  typedef struct {
    logic        iv;
    logic [63:0] pc;
    logic [31:0] ins;
    logic        ordy;
    logic        fl;
    logic        e_ir;
    logic        e_ov;
    logic [63:0] e_pc;
    logic [31:0] e_ins;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t tbl[$];

  if_id_queue #(.DEPTH(4), .PC_W(64), .INST_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_instr     (in_instr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_instr    (out_instr),
    .out_snpc     (out_snpc),
    .out_misalign (out_misalign),
    .flush        (flush),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%h want=%h", nm, cur, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic iv, input logic [63:0] pc, input logic [31:0] ins,
                              input logic ordy, input logic fl, input logic e_ir,
                              input logic e_ov, input logic [63:0] e_pc,
                              input logic [31:0] e_ins, input logic [2:0] e_cnt);
    vec_t v;
    v.iv = iv; v.pc = pc; v.ins = ins; v.ordy = ordy; v.fl = fl;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_pc = e_pc; v.e_ins = e_ins; v.e_cnt = e_cnt;
    return v;
  endfunction

  // Head-side checks after an edge. snpc and misalign are derived from the expected PC.
  task automatic chk_head(input logic e_ov, input logic [63:0] e_pc,
                          input logic [31:0] e_ins, input logic [2:0] e_cnt);
    chk("out_valid", {63'd0, out_valid}, {63'd0, e_ov});
    chk("out_pc", out_pc, e_pc);
    chk("out_instr", {32'd0, out_instr}, {32'd0, e_ins});
    chk("count", {61'd0, count}, {61'd0, e_cnt});
    chk("out_snpc", out_snpc, e_pc + 64'd4);
    chk("out_misalign", {63'd0, out_misalign}, {63'd0, (e_pc[1:0] != 2'b00)});
  endtask

  initial begin
    logic [63:0] base;
    total = 0; bad = 0; cur = -1;
    base = 64'h0000_0000_8000_0000;
    rst = 1'b0; in_valid = 1'b0; in_pc = 64'd0; in_instr = 32'd0;
    out_ready = 1'b0; flush = 1'b0;

    // Single push then pop.
    tbl.push_back(mk(1'b1, base, 32'h0000_0413, 1'b0, 1'b0, 1'b1, 1'b1, base, 32'h0000_0413, 3'd1));
    tbl.push_back(mk(1'b0, 64'd0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 64'd0, 32'd0, 3'd0));
    // Fill under back-pressure.
    for (int i = 0; i < 4; i++) begin
      tbl.push_back(mk(1'b1, base + 64'(4 * i), 32'hA0 + 32'(i), 1'b0, 1'b0, 1'b1,
                       1'b1, base, 32'hA0, 3'(i + 1)));
    end
    // A fifth request while full is not captured.
    tbl.push_back(mk(1'b1, base + 64'h10, 32'hA4, 1'b0, 1'b0, 1'b0, 1'b1, base, 32'hA0, 3'd4));
    // Full plus a simultaneous pop: the pop happens and the push is rejected.
    tbl.push_back(mk(1'b1, base + 64'h10, 32'hA4, 1'b1, 1'b0, 1'b0, 1'b1, base + 64'h4, 32'hA1, 3'd3));
    // Drain in order; in_ready is back to 1 on the first of these cycles.
    tbl.push_back(mk(1'b0, 64'd0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1, base + 64'h8, 32'hA2, 3'd2));
    tbl.push_back(mk(1'b0, 64'd0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1, base + 64'hC, 32'hA3, 3'd1));
    tbl.push_back(mk(1'b0, 64'd0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 64'd0, 32'd0, 3'd0));
    // Streaming across the pointer wrap: each head is the previous cycle's push.
    for (int k = 0; k < 10; k++) begin
      tbl.push_back(mk(1'b1, base + 64'(4 * k), 32'hB0 + 32'(k), 1'b1, 1'b0, 1'b1,
                       1'b1, base + 64'(4 * k), 32'hB0 + 32'(k), 3'd1));
    end
    // Grow to three entries, then flush with a push presented.
    tbl.push_back(mk(1'b1, base + 64'h300, 32'hC0, 1'b0, 1'b0, 1'b1, 1'b1, base + 64'h24, 32'hB9, 3'd2));
    tbl.push_back(mk(1'b1, base + 64'h304, 32'hC1, 1'b0, 1'b0, 1'b1, 1'b1, base + 64'h24, 32'hB9, 3'd3));
    tbl.push_back(mk(1'b1, base + 64'h100, 32'hCF, 1'b1, 1'b1, 1'b0, 1'b0, 64'd0, 32'd0, 3'd0));
    tbl.push_back(mk(1'b1, base + 64'h200, 32'hD0, 1'b0, 1'b0, 1'b1, 1'b1, base + 64'h200, 32'hD0, 3'd1));
    tbl.push_back(mk(1'b0, 64'd0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 64'd0, 32'd0, 3'd0));

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk_head(1'b0, 64'd0, 32'd0, 3'd0);
    @(negedge clk);
    rst = 1'b1;

    foreach (tbl[i]) begin
      cur = i;
      @(negedge clk);
      in_valid = tbl[i].iv; in_pc = tbl[i].pc; in_instr = tbl[i].ins;
      out_ready = tbl[i].ordy; flush = tbl[i].fl;
      #1;
      chk("in_ready", {63'd0, in_ready}, {63'd0, tbl[i].e_ir});
      @(posedge clk);
      #1;
      chk_head(tbl[i].e_ov, tbl[i].e_pc, tbl[i].e_ins, tbl[i].e_cnt);
    end

    // Asynchronous reset between edges at count=2.
    cur = 100;
    @(negedge clk);
    in_valid = 1'b1; in_pc = base + 64'h400; in_instr = 32'hE0; out_ready = 1'b0; flush = 1'b0;
    @(negedge clk);
    in_pc = base + 64'h404; in_instr = 32'hE1;
    @(posedge clk);
    #1;
    chk("pre_rst_count", {61'd0, count}, 64'd2);
    #2;
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("async_out_valid", {63'd0, out_valid}, 64'd0);
    chk("async_count", {61'd0, count}, 64'd0);
    chk("async_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1; in_pc = 64'hFFFF_FFFF_FFFF_FFFE; in_instr = 32'hE2;
    @(posedge clk);
    #1;
    cur = 101;
    chk_head(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 32'hE2, 3'd1);
    chk("snpc_wrap", out_snpc, 64'h0000_0000_0000_0002);

    // Reset dominates a concurrent flush.
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b1; rst = 1'b0;
    #1;
    cur = 102;
    chk_head(1'b0, 64'd0, 32'd0, 3'd0);
    flush = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Decoupling instruction queue between the fetch stage (PC register plus instruction memory read) and the decode stage.
- Buffers up to DEPTH fetched {pc, instr} pairs with valid/ready handshakes on both sides, so decode back-pressure never stalls the PC register mid-fetch.
- Supports a single-cycle flush on control-flow redirect. Also produces the static next PC (pc+4) and a misalignment flag per entry for decode.

Parameters:
- DEPTH, 4, number of entries; must be a power of two, >= 2.
- PC_W, 64, PC width in bits.
- INST_W, 32, instruction width in bits.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous reset, active-low (0 = reset).
- in_valid  input  1  fetch presents a valid {in_pc, in_instr}.
- in_ready  output  1  queue accepts the entry this cycle.
- in_pc  input  PC_W  PC of the fetched instruction.
- in_instr  input  INST_W  fetched instruction word.
- out_valid  output  1  head entry valid toward decode.
- out_ready  input  1  decode consumes the head entry this cycle.
- out_pc  output  PC_W  PC of the head entry.
- out_instr  output  INST_W  instruction of the head entry.
- out_snpc  output  PC_W  out_pc + 4, modulo 2^PC_W.
- out_misalign  output  1  out_pc[1:0] != 2'b00 for the head entry.
- flush  input  1  redirect; discards all entries.
- count  output  log2(DEPTH)+1  current number of stored entries.

Behaviour:
- Storage: circular buffer with head/tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH, and a count register. Entry payload is {pc, instr, misalign}; misalign is computed at push time.
- Reset (rst=0, asynchronous): count=0, head=0, tail=0.
  - Resulting outputs: out_valid=0, in_ready=1, out_pc=0, out_instr=0, out_snpc=4, out_misalign=0.
  - Storage array contents are don't-care.
- Reset release: first push is allowed on the first rising edge with rst=1.
- push = in_valid & in_ready & ~flush.
  - Writes the entry at tail; tail <= tail+1.
- pop = out_valid & out_ready & ~flush.
  - head <= head+1.
- count <= count + push - pop.
  - Simultaneous push and pop leaves count unchanged and advances both pointers.
- in_ready = (count != DEPTH) & ~flush. Purely combinational from registered state plus flush.
  - When full, no push is accepted even if a pop occurs in the same cycle (no full-bypass).
- out_valid = (count != 0).
- out_pc, out_instr and out_misalign are read combinationally from the head entry.
  - When count==0 they are forced to 0 (out_snpc is then 4).
- No empty-bypass: latency from an accepted push to out_valid is exactly 1 cycle.
- Throughput: 1 entry/cycle sustained when out_ready=1.
- Ordering: strict FIFO; entries are never reordered or duplicated.
- Payload stability: while out_valid=1 and out_ready=0, the out_* payload holds stable.
- flush=1 (synchronous, highest priority):
  - Next edge: count=0, head=0, tail=0.
  - A push presented in the flush cycle is dropped (in_ready=0 that cycle).
  - A pop in the flush cycle is not counted; decode must ignore out_valid when flush=1.
- Flush and reset together: reset dominates (asynchronous).
- Reset asserted mid-operation: all state clears immediately, regardless of clock.
- Arithmetic: out_snpc wraps, so 0xFFFF_FFFF_FFFF_FFFC + 4 = 0.
- Misalign is informational only; misaligned entries are queued and popped normally.
- in_valid=1 while in_ready=0 is legal. The fetch side holds its request; the queue does not capture it.

Test Plan:
- Reset then single push: rst low 2 cycles, release; push pc=0x8000_0000, instr=0x0000_0413 -> next cycle out_valid=1, out_pc=0x8000_0000, out_instr=0x0000_0413, out_snpc=0x8000_0004, count=1.
- Fill and back-pressure: out_ready=0; push pcs 0x8000_0000, 0x8000_0004, 0x8000_0008, 0x8000_000C -> count=4, in_ready=0. A 5th in_valid with pc 0x8000_0010 is not accepted. Then out_ready=1 pops in order 0x..00, 0x..04, 0x..08, 0x..0C.
- Streaming with wrap: in_valid=1 and out_ready=1 for 10 cycles with pcs incrementing by 4 from 0x8000_0000 -> count stays at 1 after the first cycle. Output sequence equals input delayed by 1 cycle, across pointer wrap.
- Full plus simultaneous pop: at count=4, out_ready=1 and in_valid=1 -> pop occurs, push rejected, count=3. Following cycle in_ready=1.
- Flush mid-stream: count=3, then flush=1 with in_valid=1 (pc 0x8000_0100) -> in_ready=0 that cycle. Next cycle count=0, out_valid=0. A subsequent push of 0x8000_0200 appears as the head one cycle later.
- Async reset and edge values: assert rst=0 between clock edges at count=2 -> out_valid drops immediately. After release, push pc=0xFFFF_FFFF_FFFF_FFFE -> out_misalign=1, out_snpc=0x0000_0000_0000_0002.
